// File: rtl/switch_debounce_if.sv
// Switch debouncer bus: raw switch levels in, debounced levels, change pulse
// and sticky edge-capture/interrupt out.
interface switch_debounce_if #(
  parameter int WIDTH = 10
);
  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] sw_out;
  logic             sw_changed;
  logic [WIDTH-1:0] edge_clear;
  logic [WIDTH-1:0] edge_capture;
  logic             irq;

  modport master (
    output sw_raw,
    output edge_clear,
    input  sw_out,
    input  sw_changed,
    input  edge_capture,
    input  irq
  );

  modport slave (
    input  sw_raw,
    input  edge_clear,
    output sw_out,
    output sw_changed,
    output edge_capture,
    output irq
  );
endinterface

// File: rtl/switch_debounce.sv
// Per-bit synchronizer plus saturating stability counter for mechanical switches.
// Optional sticky edge capture and irq enabled by SWITCH_DEBOUNCE_EDGE_CAPTURE_EN.
module switch_debounce #(
  parameter int WIDTH           = 10,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  switch_debounce_if.slave bus
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  logic [WIDTH-1:0] sync1_reg;
  logic [WIDTH-1:0] sync2_reg;
  logic [WIDTH-1:0] out_reg;
  logic             changed_reg;
  logic [WIDTH-1:0] load;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= bus.sw_raw;
      sync2_reg <= sync1_reg;
    end
  end

  // Each bit counts how long sync2 has disagreed with the accepted level;
  // any agreement restarts the count, so short glitches never load.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic [CW-1:0] cnt_reg;
      logic          differ;

      assign differ    = sync2_reg[gi] != out_reg[gi];
      assign load[gi]  = differ && (cnt_reg == CNT_LAST);

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt_reg <= '0;
        end else if (!differ || load[gi]) begin
          cnt_reg <= '0;
        end else if (cnt_reg != CNT_MAX) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_reg     <= '0;
      changed_reg <= 1'b0;
    end else begin
      out_reg     <= (out_reg & ~load) | (sync2_reg & load);
      changed_reg <= |load;
    end
  end

  assign bus.sw_out     = out_reg;
  assign bus.sw_changed = changed_reg;

`ifdef SWITCH_DEBOUNCE_EDGE_CAPTURE_EN
  logic [WIDTH-1:0] capture_reg;
  logic             irq_reg;

  // A new edge in the same cycle as its clear must not be lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      capture_reg <= '0;
      irq_reg     <= 1'b0;
    end else begin
      capture_reg <= (capture_reg & ~bus.edge_clear) | load;
      irq_reg     <= |capture_reg;
    end
  end

  assign bus.edge_capture = capture_reg;
  assign bus.irq          = irq_reg;
`else
  logic unused_edge_clear;
  assign unused_edge_clear = ^bus.edge_clear;

  assign bus.edge_capture = '0;
  assign bus.irq          = 1'b0;
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce with DEBOUNCE_CYCLES=4; edge-capture
// expectations follow SWITCH_DEBOUNCE_EDGE_CAPTURE_EN.
module tb_switch_debounce;
  localparam int W  = 10;
  localparam int DC = 4;
`ifdef SWITCH_DEBOUNCE_EDGE_CAPTURE_EN
  localparam bit EC = 1'b1;
`else
  localparam bit EC = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  switch_debounce_if #(.WIDTH(W)) bus ();

  switch_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(DC)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ec(input logic [W-1:0] v);
    return EC ? v : '0;
  endfunction

  initial begin
    bus.sw_raw     = '0;
    bus.edge_clear = '0;

    // reset state
    tick(2);
    check("rst_out", bus.sw_out, '0);
    check("rst_chg", W'(bus.sw_changed), '0);
    check("rst_cap", bus.edge_capture, '0);
    check("rst_irq", W'(bus.irq), '0);
    reset_n = 1'b1;

    // clean press: sw_out rises 6 edges later
    bus.sw_raw = 10'h001;
    tick(5);
    check("press_wait", bus.sw_out, 10'h000);
    tick();
    check("press_out", bus.sw_out, 10'h001);
    check("press_chg", W'(bus.sw_changed), 1);
    check("press_cap", bus.edge_capture, ec(10'h001));
    check("press_irq_lag", W'(bus.irq), 0);
    tick();
    check("press_chg_end", W'(bus.sw_changed), 0);
    check("press_irq", W'(bus.irq), ec(1));

    // write-one-to-clear
    bus.edge_clear = 10'h001;
    tick();
    bus.edge_clear = '0;
    check("clr_cap", bus.edge_capture, '0);
    check("clr_irq_lag", W'(bus.irq), ec(1));
    tick();
    check("clr_irq", W'(bus.irq), 0);

    // release of bit 0 also captures an edge
    bus.sw_raw = 10'h000;
    tick(6);
    check("rel_out", bus.sw_out, 10'h000);
    check("rel_chg", W'(bus.sw_changed), 1);
    check("rel_cap", bus.edge_capture, ec(10'h001));
    bus.edge_clear = 10'h001;
    tick();
    bus.edge_clear = '0;
    tick();
    check("rel_clr_cap", bus.edge_capture, '0);
    check("rel_clr_irq", W'(bus.irq), 0);

    // glitch of 3 cycles is rejected
    bus.sw_raw = 10'h008;
    tick(3);
    bus.sw_raw = 10'h000;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("glitch_out_%0d", i), bus.sw_out, 10'h000);
      check($sformatf("glitch_chg_%0d", i), W'(bus.sw_changed), 0);
    end

    // bounce 1,0,1,1,... on bit 5
    bus.sw_raw = 10'h020;
    tick();
    bus.sw_raw = 10'h000;
    tick();
    bus.sw_raw = 10'h020;
    tick(5);
    check("bounce_wait", bus.sw_out, 10'h000);
    tick();
    check("bounce_out", bus.sw_out, 10'h020);
    check("bounce_chg", W'(bus.sw_changed), 1);
    bus.sw_raw = 10'h000;
    tick(6);
    check("bounce_rel", bus.sw_out, 10'h000);
    bus.edge_clear = 10'h3FF;
    tick();
    bus.edge_clear = '0;

    // all bits at once: one update, one pulse
    bus.sw_raw = 10'h3FF;
    tick(5);
    check("multi_wait", bus.sw_out, 10'h000);
    tick();
    check("multi_out", bus.sw_out, 10'h3FF);
    check("multi_chg", W'(bus.sw_changed), 1);
    check("multi_cap", bus.edge_capture, ec(10'h3FF));
    tick();
    check("multi_chg_end", W'(bus.sw_changed), 0);
    bus.sw_raw = 10'h000;
    tick(6);
    check("multi_rel", bus.sw_out, 10'h000);
    tick();
    check("pre_rst_cap", bus.edge_capture, ec(10'h3FF));
    check("pre_rst_irq", W'(bus.irq), ec(1));

    // reset mid-count: count reaches 2, then reset for one cycle
    bus.sw_raw = 10'h200;
    tick(4);
    reset_n = 1'b0;
    #1;
    check("rst_async_out", bus.sw_out, '0);
    check("rst_async_cap", bus.edge_capture, '0);
    check("rst_async_irq", W'(bus.irq), 0);
    tick();
    check("rst_hold_out", bus.sw_out, '0);
    check("rst_hold_chg", W'(bus.sw_changed), 0);
    reset_n = 1'b1;
    tick(5);
    check("rst_wait", bus.sw_out, 10'h000);
    tick();
    check("rst_out_final", bus.sw_out, 10'h200);
    check("rst_chg_final", W'(bus.sw_changed), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
